// File: rtl/vending_pkg.sv
// Shared constants for the vending controller: state encodings and coin codes.
package vending_pkg;

    // Credit states; 2'b01 is deliberately unused and recovers to S0.
    localparam logic [1:0] S0 = 2'b00;  // 0c credit
    localparam logic [1:0] S1 = 2'b10;  // 5c credit
    localparam logic [1:0] S2 = 2'b11;  // 10c credit

    // Coin acceptor codes, one coin per clock.
    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_NICKEL = 2'b01;
    localparam logic [1:0] COIN_DIME   = 2'b10;
    localparam logic [1:0] COIN_BAD    = 2'b11;

    // Fixed pricing in cents.
    localparam int unsigned PRICE  = 15;
    localparam int unsigned NICKEL = 5;
    localparam int unsigned DIME   = 10;

endpackage

// File: rtl/vending_machine.sv
// 15c vending controller taking nickels and dimes. Dispense (x) and 5c change (y)
// are registered single-cycle pulses issued on the edge that completes a sale.
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coin,
    output logic       x,
    output logic       y
);

    logic [1:0] state_q, state_d;
    logic       x_q, x_d;
    logic       y_q, y_d;

    // Next credit state and next pulse values from current credit and the sampled coin.
    always_comb begin
        state_d = state_q;
        x_d     = 1'b0;
        y_d     = 1'b0;
        unique case (state_q)
            S0: begin
                case (coin)
                    COIN_NICKEL: state_d = S1;
                    COIN_DIME:   state_d = S2;
                    default:     state_d = S0;  // none or invalid coin: hold
                endcase
            end
            S1: begin
                case (coin)
                    COIN_NICKEL: state_d = S2;
                    COIN_DIME: begin
                        state_d = S0;
                        x_d     = 1'b1;
                    end
                    default:     state_d = S1;
                endcase
            end
            S2: begin
                case (coin)
                    COIN_NICKEL: begin
                        state_d = S0;
                        x_d     = 1'b1;
                    end
                    COIN_DIME: begin
                        // 20c taken: vend and return one nickel.
                        state_d = S0;
                        x_d     = 1'b1;
                        y_d     = 1'b1;
                    end
                    default:     state_d = S2;
                endcase
            end
            default: begin
                // Unused encoding: drop back to empty credit without vending.
                state_d = S0;
            end
        endcase
    end

    // State and output register; synchronous reset discards any partial credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench: directed scenarios then random coins/resets, compared with a
// credit-in-cents reference model.
module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic [1:0] coin;
    logic       x;
    logic       y;

    int unsigned n_checks;
    int unsigned n_fails;

    // Reference model: credit in cents plus last pulse values.
    int unsigned m_credit;
    logic        m_x;
    logic        m_y;

    vending_machine dut (
        .clk  (clk),
        .rst  (rst),
        .coin (coin),
        .x    (x),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected state encoding for a credit amount.
    function automatic logic [1:0] credit_code(input int unsigned c);
        case (c)
            0:       return 2'b00;
            5:       return 2'b10;
            10:      return 2'b11;
            default: return 2'bxx;
        endcase
    endfunction

    function automatic int unsigned coin_cents(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            default: return 0;
        endcase
    endfunction

    // Model one rising edge from the specification's pricing rules.
    task automatic model_edge(input logic r, input logic [1:0] c);
        int unsigned total;
        m_x = 1'b0;
        m_y = 1'b0;
        if (r) begin
            m_credit = 0;
        end else begin
            total = m_credit + coin_cents(c);
            if (total >= 15) begin
                m_x      = 1'b1;
                m_y      = (total - 15 == 5);
                m_credit = 0;
            end else begin
                m_credit = total;
            end
        end
    endtask

    // Drive away from the edge, clock once, then compare.
    task automatic step(input string tag, input logic r, input logic [1:0] c);
        @(negedge clk);
        rst  = r;
        coin = c;
        @(posedge clk);
        #1;
        model_edge(r, c);
        check_eq({tag, ".x"}, {1'b0, x}, {1'b0, m_x});
        check_eq({tag, ".y"}, {1'b0, y}, {1'b0, m_y});
        check_eq({tag, ".state"}, dut.state_q, credit_code(m_credit));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        m_credit = 0;
        m_x      = 1'b0;
        m_y      = 1'b0;
        rst      = 1'b0;
        coin     = 2'b00;

        // Reset wins over a dime in the same cycle.
        step("rst_dime", 1'b1, 2'b10);
        check_eq("rst_x_const", {x, y}, 2'b00);

        // Dime, idle, nickel -> plain vend.
        step("t2_dime", 1'b0, 2'b10);
        step("t2_idle", 1'b0, 2'b00);
        step("t2_nick", 1'b0, 2'b01);
        check_eq("t2_vend", {x, y}, 2'b10);
        step("t2_after", 1'b0, 2'b00);
        check_eq("t2_clear", {x, y}, 2'b00);

        // Dime, invalid, dime -> vend with change.
        step("t3_dime", 1'b0, 2'b10);
        step("t3_bad", 1'b0, 2'b11);
        step("t3_dime2", 1'b0, 2'b10);
        check_eq("t3_vend", {x, y}, 2'b11);

        // Three nickels.
        step("t4_n1", 1'b0, 2'b01);
        step("t4_n2", 1'b0, 2'b01);
        step("t4_n3", 1'b0, 2'b01);
        check_eq("t4_vend", {x, y}, 2'b10);

        // Nickel then dime.
        step("t5_n", 1'b0, 2'b01);
        step("t5_d", 1'b0, 2'b10);
        check_eq("t5_vend", {x, y}, 2'b10);

        // Back-to-back: from 10c, dime then dime.
        step("bb_d1", 1'b0, 2'b10);
        step("bb_d2", 1'b0, 2'b10);
        step("bb_d3", 1'b0, 2'b10);
        check_eq("bb_state", dut.state_q, 2'b11);

        // Reset mid-transaction discards credit, then a normal vend.
        step("t6_to0", 1'b1, 2'b00);
        step("t6_n", 1'b0, 2'b01);
        step("t6_rst", 1'b1, 2'b10);
        step("t6_d", 1'b0, 2'b10);
        step("t6_n2", 1'b0, 2'b01);
        check_eq("t6_vend", {x, y}, 2'b10);

        // Random coins with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)));
            if (y && !x) check_eq("y_without_x", {x, y}, 2'b10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
